// File: rtl/uart_mmio_if.sv
// Data-bus slice shared by the byte-addressed data memory and the UART window.
interface uart_mmio_if;
  logic [1:0]  WE;
  logic [2:0]  READMODE;
  logic        RE;
  logic [31:0] ADDR;
  logic [31:0] WD;
  logic [31:0] RD;
  logic        SEL;

  modport master (output WE, READMODE, RE, ADDR, WD, input RD, SEL);
  modport slave  (input WE, READMODE, RE, ADDR, WD, output RD, SEL);
endinterface

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART with TX/RX FIFOs and sticky status flags.
// Optional CTRL register with internal loopback when UART_LOOPBACK_EN is defined.
module uart_mmio #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0400,
  parameter int          CLKS_PER_BIT = 10417,
  parameter int          FIFO_DEPTH   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  uart_mmio_if.slave bus,
  output logic       tx,
  input  logic       rx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);
`ifdef UART_LOOPBACK_EN
  localparam logic [31:0] WIN_LAST = 32'd15;
`else
  localparam logic [31:0] WIN_LAST = 32'd11;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_t;

  logic [31:0] off_s;
  logic        sel_s, wr_s, hit_tx_s, hit_rx_s, hit_st_s;
  logic        unused_wd_s;

  assign off_s    = bus.ADDR - BASE_ADDR;
  assign sel_s    = (off_s <= WIN_LAST);
  assign wr_s     = (bus.WE != 2'b00);
  assign hit_tx_s = sel_s && (off_s[3:0] == 4'h0);
  assign hit_rx_s = sel_s && (off_s[3:0] == 4'h4);
  assign hit_st_s = sel_s && (off_s[3:0] == 4'h8);
  assign bus.SEL  = sel_s;
  assign unused_wd_s = &{1'b0, bus.WD[31:8]};

  // ---------------- TX FIFO and serialiser ----------------
  logic [7:0]  tx_mem_r [FIFO_DEPTH];
  logic [AW:0] tx_wp_r, tx_rp_r, tx_cnt_s;
  logic        tx_full_s, tx_empty_s, tx_push_s, tx_pop_s, tx_ovf_set_s, tx_idle_s;
  logic [7:0]  tx_head_s;
  uart_state_t tx_state_r, tx_state_n;
  logic [CW-1:0] tx_clk_r, tx_clk_n;
  logic [2:0]  tx_bit_r, tx_bit_n;
  logic [7:0]  tx_shift_r, tx_shift_n;
  logic        tx_line_r, tx_line_n;

  assign tx_cnt_s   = tx_wp_r - tx_rp_r;
  assign tx_full_s  = (tx_cnt_s == DEPTH_C);
  assign tx_empty_s = (tx_cnt_s == {(AW + 1){1'b0}});
  assign tx_head_s  = tx_mem_r[tx_rp_r[AW-1:0]];
  // The FSM also pops on the last stop-bit cycle so frames run back-to-back.
  assign tx_pop_s   = !tx_empty_s && ((tx_state_r == S_IDLE) ||
                      ((tx_state_r == S_STOP) && (tx_clk_r == BIT_LAST)));
  assign tx_push_s    = wr_s && hit_tx_s && (!tx_full_s || tx_pop_s);
  assign tx_ovf_set_s = wr_s && hit_tx_s && tx_full_s && !tx_pop_s;
  assign tx_idle_s    = tx_empty_s && (tx_state_r == S_IDLE);

  // TX next-state, bit timing and serial line value
  always_comb begin
    tx_state_n = tx_state_r;
    tx_clk_n   = tx_clk_r + CNT_ONE;
    tx_bit_n   = tx_bit_r;
    tx_shift_n = tx_shift_r;
    tx_line_n  = tx_line_r;
    case (tx_state_r)
      S_IDLE: begin
        tx_clk_n  = CNT_ZERO;
        tx_line_n = 1'b1;
        if (tx_pop_s) begin
          tx_state_n = S_START;
          tx_shift_n = tx_head_s;
          tx_line_n  = 1'b0;
        end else begin
          tx_state_n = S_IDLE;
        end
      end
      S_START: begin
        if (tx_clk_r == BIT_LAST) begin
          tx_state_n = S_DATA;
          tx_clk_n   = CNT_ZERO;
          tx_bit_n   = 3'd0;
          tx_line_n  = tx_shift_r[0];
        end else begin
          tx_state_n = S_START;
        end
      end
      S_DATA: begin
        if (tx_clk_r == BIT_LAST) begin
          tx_clk_n = CNT_ZERO;
          if (tx_bit_r == 3'd7) begin
            tx_state_n = S_STOP;
            tx_line_n  = 1'b1;
          end else begin
            tx_bit_n   = tx_bit_r + 3'd1;
            tx_shift_n = {1'b0, tx_shift_r[7:1]};
            tx_line_n  = tx_shift_r[1];
          end
        end else begin
          tx_state_n = S_DATA;
        end
      end
      S_STOP: begin
        if (tx_clk_r == BIT_LAST) begin
          tx_clk_n = CNT_ZERO;
          if (tx_pop_s) begin
            tx_state_n = S_START;
            tx_shift_n = tx_head_s;
            tx_line_n  = 1'b0;
          end else begin
            tx_state_n = S_IDLE;
            tx_line_n  = 1'b1;
          end
        end else begin
          tx_state_n = S_STOP;
        end
      end
      default: begin
        tx_state_n = S_IDLE;
        tx_clk_n   = CNT_ZERO;
        tx_line_n  = 1'b1;
      end
    endcase
  end

  // TX state register and FIFO pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_r <= S_IDLE;
      tx_clk_r   <= CNT_ZERO;
      tx_bit_r   <= 3'd0;
      tx_shift_r <= 8'd0;
      tx_line_r  <= 1'b1;
      tx_wp_r    <= {(AW + 1){1'b0}};
      tx_rp_r    <= {(AW + 1){1'b0}};
    end else begin
      tx_state_r <= tx_state_n;
      tx_clk_r   <= tx_clk_n;
      tx_bit_r   <= tx_bit_n;
      tx_shift_r <= tx_shift_n;
      tx_line_r  <= tx_line_n;
      if (tx_push_s) tx_wp_r <= tx_wp_r + PTR_ONE;
      if (tx_pop_s)  tx_rp_r <= tx_rp_r + PTR_ONE;
    end
  end

  // ---------------- RX synchroniser, deserialiser and FIFO ----------------
  logic        rx_src_s, rx_sync1_r, rx_sync2_r, rx_prev_r;
  uart_state_t rx_state_r, rx_state_n;
  logic [CW-1:0] rx_clk_r, rx_clk_n;
  logic [2:0]  rx_bit_r, rx_bit_n;
  logic [7:0]  rx_shift_r, rx_shift_n;
  logic        rx_done_s, ferr_set_s;
  logic [7:0]  rx_mem_r [FIFO_DEPTH];
  logic [AW:0] rx_wp_r, rx_rp_r, rx_cnt_s;
  logic        rx_full_s, rx_empty_s, rx_push_s, rx_pop_s, rx_ovf_set_s;
  logic [7:0]  rx_head_s;

  assign rx_cnt_s     = rx_wp_r - rx_rp_r;
  assign rx_full_s    = (rx_cnt_s == DEPTH_C);
  assign rx_empty_s   = (rx_cnt_s == {(AW + 1){1'b0}});
  assign rx_head_s    = rx_mem_r[rx_rp_r[AW-1:0]];
  assign rx_pop_s     = bus.RE && hit_rx_s && !rx_empty_s;
  assign rx_push_s    = rx_done_s && (!rx_full_s || rx_pop_s);
  assign rx_ovf_set_s = rx_done_s && rx_full_s && !rx_pop_s;

  // RX next-state with mid-bit sampling
  always_comb begin
    rx_state_n = rx_state_r;
    rx_clk_n   = rx_clk_r + CNT_ONE;
    rx_bit_n   = rx_bit_r;
    rx_shift_n = rx_shift_r;
    rx_done_s  = 1'b0;
    ferr_set_s = 1'b0;
    case (rx_state_r)
      S_IDLE: begin
        rx_clk_n = CNT_ZERO;
        if (rx_prev_r && !rx_sync2_r) begin
          rx_state_n = S_START;
        end else begin
          rx_state_n = S_IDLE;
        end
      end
      S_START: begin
        if (rx_clk_r == HALF_LAST) begin
          rx_clk_n = CNT_ZERO;
          rx_bit_n = 3'd0;
          if (rx_sync2_r) begin
            rx_state_n = S_IDLE;
          end else begin
            rx_state_n = S_DATA;
          end
        end else begin
          rx_state_n = S_START;
        end
      end
      S_DATA: begin
        if (rx_clk_r == BIT_LAST) begin
          rx_clk_n   = CNT_ZERO;
          rx_shift_n = {rx_sync2_r, rx_shift_r[7:1]};
          if (rx_bit_r == 3'd7) begin
            rx_state_n = S_STOP;
          end else begin
            rx_bit_n = rx_bit_r + 3'd1;
          end
        end else begin
          rx_state_n = S_DATA;
        end
      end
      S_STOP: begin
        if (rx_clk_r == BIT_LAST) begin
          rx_state_n = S_IDLE;
          rx_clk_n   = CNT_ZERO;
          rx_done_s  = rx_sync2_r;
          ferr_set_s = !rx_sync2_r;
        end else begin
          rx_state_n = S_STOP;
        end
      end
      default: begin
        rx_state_n = S_IDLE;
        rx_clk_n   = CNT_ZERO;
      end
    endcase
  end

  // RX synchroniser, state register and FIFO pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync1_r <= 1'b1;
      rx_sync2_r <= 1'b1;
      rx_prev_r  <= 1'b1;
      rx_state_r <= S_IDLE;
      rx_clk_r   <= CNT_ZERO;
      rx_bit_r   <= 3'd0;
      rx_shift_r <= 8'd0;
      rx_wp_r    <= {(AW + 1){1'b0}};
      rx_rp_r    <= {(AW + 1){1'b0}};
    end else begin
      rx_sync1_r <= rx_src_s;
      rx_sync2_r <= rx_sync1_r;
      rx_prev_r  <= rx_sync2_r;
      rx_state_r <= rx_state_n;
      rx_clk_r   <= rx_clk_n;
      rx_bit_r   <= rx_bit_n;
      rx_shift_r <= rx_shift_n;
      if (rx_push_s) rx_wp_r <= rx_wp_r + PTR_ONE;
      if (rx_pop_s)  rx_rp_r <= rx_rp_r + PTR_ONE;
    end
  end

  // FIFO storage; contents are qualified by the pointers so need no reset
  always_ff @(posedge clk) begin
    if (tx_push_s) tx_mem_r[tx_wp_r[AW-1:0]] <= bus.WD[7:0];
    if (rx_push_s) rx_mem_r[rx_wp_r[AW-1:0]] <= rx_shift_r;
  end

  // ---------------- sticky flags ----------------
  logic [2:0] clr_s;
  logic       tx_ovf_r, rx_ovf_r, ferr_r;

  assign clr_s = (wr_s && hit_st_s) ? bus.WD[6:4] : 3'b000;

  // Set events win over a same-cycle write-1-to-clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_ovf_r <= 1'b0;
      rx_ovf_r <= 1'b0;
      ferr_r   <= 1'b0;
    end else begin
      tx_ovf_r <= (tx_ovf_r && !clr_s[0]) || tx_ovf_set_s;
      rx_ovf_r <= (rx_ovf_r && !clr_s[1]) || rx_ovf_set_s;
      ferr_r   <= (ferr_r   && !clr_s[2]) || ferr_set_s;
    end
  end

  // ---------------- optional loopback ----------------
`ifdef UART_LOOPBACK_EN
  logic hit_ctrl_s, lb_r, lb_n, tx_pin_r;

  assign hit_ctrl_s = sel_s && (off_s[3:0] == 4'hC);

  // CTRL write decode
  always_comb begin
    if (wr_s && hit_ctrl_s) begin
      lb_n = bus.WD[0];
    end else begin
      lb_n = lb_r;
    end
  end

  // Loopback bit and the pin register, held idle while looping back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lb_r     <= 1'b0;
      tx_pin_r <= 1'b1;
    end else begin
      lb_r     <= lb_n;
      tx_pin_r <= lb_n || tx_line_n;
    end
  end

  assign tx       = tx_pin_r;
  assign rx_src_s = lb_r ? tx_line_r : rx;
`else
  assign tx       = tx_line_r;
  assign rx_src_s = rx;
`endif

  // ---------------- read mux ----------------
  logic [31:0] status_s, rd_s;

  assign status_s = {16'd0, 8'(rx_cnt_s), 1'b0, ferr_r, rx_ovf_r, tx_ovf_r,
                     rx_full_s, rx_empty_s, tx_idle_s, tx_full_s};

  // Register read data; unmapped, misaligned and write-only offsets read 0
  always_comb begin
    rd_s = 32'd0;
    if (hit_rx_s && !rx_empty_s) begin
      case (bus.READMODE)
        3'b000, 3'b001, 3'b010: rd_s = {24'd0, rx_head_s};
        3'b011, 3'b110:         rd_s = {{24{rx_head_s[7]}}, rx_head_s};
        default:                rd_s = 32'd0;
      endcase
    end else if (hit_st_s) begin
      rd_s = status_s;
`ifdef UART_LOOPBACK_EN
    end else if (hit_ctrl_s) begin
      rd_s = {31'd0, lb_r};
`endif
    end else begin
      rd_s = 32'd0;
    end
  end

  assign bus.RD = rd_s;
endmodule

// File: tb/tb_uart_mmio.sv
// Randomised scoreboard bench for uart_mmio (CLKS_PER_BIT=4, FIFO_DEPTH=4).
module tb_uart_mmio;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rx    = 1'b1;
  logic tx;

  uart_mmio_if bus();

  uart_mmio #(.BASE_ADDR(32'h0000_0400), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .tx(tx), .rx(rx)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] rd_exp[$];
  string       rd_name[$];
  logic [7:0]  tx_exp[$];
  logic [7:0]  rx_m[$];
  logic        tx_ovf_m = 1'b0;
  logic        rx_ovf_m = 1'b0;
  logic        ferr_m   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fmt(input logic [7:0] b, input logic [2:0] m);
    if (m == 3'b000 || m == 3'b001 || m == 3'b010) return {24'd0, b};
    else if (m == 3'b011 || m == 3'b110) return 32'($signed(b));
    else return 32'd0;
  endfunction

  // txb = {TX_IDLE, TX_FULL}; everything else from the RX model and flags
  function automatic logic [31:0] exp_status(input logic [1:0] txb);
    int n;
    n = rx_m.size();
    return {16'd0, 8'(n), 1'b0, ferr_m, rx_ovf_m, tx_ovf_m,
            (n == DEPTH), (n == 0), txb};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] wd, input logic [1:0] we);
    bus.ADDR = addr;
    bus.WD   = wd;
    bus.WE   = we;
    @(posedge clk);
    #1;
    bus.WE = 2'b00;
  endtask

  task automatic load(input string name, input logic [31:0] addr, input logic [2:0] mode,
                      input logic [31:0] exp);
    bus.ADDR     = addr;
    bus.READMODE = mode;
    bus.RE       = 1'b1;
    rd_exp.push_back(exp);
    rd_name.push_back(name);
    @(posedge clk);
    #1;
    bus.RE = 1'b0;
  endtask

  task automatic read_rx(input string name, input logic [2:0] mode);
    logic [31:0] e;
    if (rx_m.size() == 0) e = 32'd0;
    else e = fmt(rx_m.pop_front(), mode);
    load(name, 32'h0000_0404, mode, e);
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      idle(CPB);
    end
    rx = 1'b1;
    idle(2 * CPB);
    if (!stop_bit) ferr_m = 1'b1;
    else if (rx_m.size() < DEPTH) rx_m.push_back(b);
    else rx_ovf_m = 1'b1;
  endtask

  task automatic wait_tx_drain();
    int n;
    n = 0;
    while (tx_exp.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (tx_exp.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL tx_drain_timeout: %0d frames outstanding, expected 0", tx_exp.size());
    end
    idle(CPB);
  endtask

  // Read scoreboard: compares RD whenever a load hits the window
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.RE && bus.SEL) begin
        if (rd_exp.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL rd_unexpected: got 0x%08h, expected no read", bus.RD);
        end else begin
          check(rd_name.pop_front(), bus.RD, rd_exp.pop_front());
        end
      end
    end
  end

  // Serial monitor: decodes tx frames at mid-bit and compares with queued bytes
  initial begin
    int   cnt;
    bit   act;
    logic [7:0] got;
    cnt = 0;
    act = 1'b0;
    got = 8'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        act = 1'b0;
        cnt = 0;
      end else if (!act) begin
        if (tx === 1'b0) begin
          act = 1'b1;
          cnt = 0;
        end
      end else begin
        cnt++;
        if (cnt == CPB / 2) begin
          check("tx_start_bit", {31'd0, tx}, 32'd0);
        end else if (cnt >= CPB + CPB / 2 && cnt < 9 * CPB && ((cnt - CPB / 2) % CPB) == 0) begin
          got[(cnt - CPB - CPB / 2) / CPB] = tx;
        end else if (cnt == 9 * CPB + CPB / 2) begin
          check("tx_stop_bit", {31'd0, tx}, 32'd1);
          if (tx_exp.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL tx_unexpected_frame: got 0x%02h, expected no frame", got);
          end else begin
            check("tx_byte", {24'd0, got}, {24'd0, tx_exp.pop_front()});
          end
          act = 1'b0;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    logic [7:0]  b;
    logic [2:0]  m;
    logic [1:0]  we;
    bit          saw_low;
    bus.WE = 2'b00; bus.RE = 1'b0; bus.ADDR = 32'd0; bus.WD = 32'd0; bus.READMODE = 3'b000;

    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", {31'd0, tx}, 32'd1);
    rst_n = 1'b1;
    idle(2);
    check("reset_sel_outside", {31'd0, bus.SEL}, 32'd0);
    check("reset_rd_outside", bus.RD, 32'd0);
    load("reset_status", 32'h0000_0408, 3'b000, exp_status(2'b10));

    // Directed 0xA5 frame with start latency
    tx_exp.push_back(8'hA5);
    store(32'h0000_0400, 32'h0000_00A5, 2'b11);
    check("tx_idle_after_push", {31'd0, tx}, 32'd1);
    idle(1);
    check("tx_start_latency", {31'd0, tx}, 32'd0);
    wait_tx_drain();
    load("status_after_a5", 32'h0000_0408, 3'b101, exp_status(2'b10));

    // Random stores of any width, plus ignored misaligned / WE=00 writes
    for (int i = 0; i < 4; i++) begin
      w  = $urandom;
      we = 2'($urandom_range(1, 3));
      tx_exp.push_back(w[7:0]);
      store(32'h0000_0400, w, we);
      store(32'h0000_0401, $urandom, 2'b11);
      store(32'h0000_0400, $urandom, 2'b00);
      wait_tx_drain();
    end
    load("txdata_reads_zero", 32'h0000_0400, 3'b000, 32'd0);

    // TX overflow: 0x01 starts at once, 0x02..0x05 fill, 0x06 is dropped
    for (int i = 1; i <= 6; i++) begin
      if (i <= 5) tx_exp.push_back(8'(i));
      store(32'h0000_0400, 32'(i), 2'b11);
    end
    tx_ovf_m = 1'b1;
    load("status_tx_ovf", 32'h0000_0408, 3'b000, exp_status(2'b01));
    store(32'h0000_0408, 32'h0000_0010, 2'b10);
    tx_ovf_m = 1'b0;
    load("status_tx_ovf_clr", 32'h0000_0408, 3'b000, exp_status(2'b01));
    wait_tx_drain();
    load("status_tx_drained", 32'h0000_0408, 3'b000, exp_status(2'b10));

    // RX directed bytes and a write to RXDATA that must be ignored
    store(32'h0000_0404, 32'h0000_00FF, 2'b11);
    rx_frame(8'h3C, 1'b1);
    load("status_rx_one", 32'h0000_0408, 3'b000, exp_status(2'b10));
    load("rx_misaligned", 32'h0000_0405, 3'b000, 32'd0);
    read_rx("rx_lb_3c", 3'b110);
    load("status_rx_popped", 32'h0000_0408, 3'b000, exp_status(2'b10));
    rx_frame(8'hF0, 1'b1);
    read_rx("rx_lb_f0", 3'b110);

    // RX random bytes under random load formats
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      m = 3'($urandom_range(0, 7));
      rx_frame(b, 1'b1);
      read_rx("rx_rand", m);
    end
    read_rx("rx_empty_read", 3'b000);

    // Window edges
    bus.ADDR = 32'h0000_040B;
    #1;
    check("sel_last_byte", {31'd0, bus.SEL}, 32'd1);
    bus.ADDR = 32'h0000_03FF;
    #1;
    check("sel_below_base", {31'd0, bus.SEL}, 32'd0);

    // Framing error, then a one-cycle glitch on idle
    rx_frame(8'h55, 1'b0);
    load("status_ferr", 32'h0000_0408, 3'b000, exp_status(2'b10));
    store(32'h0000_0408, 32'h0000_0040, 2'b01);
    ferr_m = 1'b0;
    rx = 1'b0;
    idle(1);
    rx = 1'b1;
    idle(12 * CPB);
    load("status_glitch", 32'h0000_0408, 3'b000, exp_status(2'b10));

    // RX overflow: five frames, four stored
    for (int i = 0; i < 5; i++) rx_frame(8'($urandom), 1'b1);
    load("status_rx_ovf", 32'h0000_0408, 3'b000, exp_status(2'b10));
    read_rx("rx_after_ovf", 3'b000);
    load("status_rx_three", 32'h0000_0408, 3'b000, exp_status(2'b10));

    // Reset in the middle of a TX frame
    tx_exp.push_back(8'h00);
    store(32'h0000_0400, 32'h0000_0000, 2'b11);
    idle(12);
    #1;
    rst_n = 1'b0;
    #1;
    check("tx_async_reset", {31'd0, tx}, 32'd1);
    tx_exp.delete();
    rx_m.delete();
    tx_ovf_m = 1'b0; rx_ovf_m = 1'b0; ferr_m = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(2);
    check("tx_after_reset", {31'd0, tx}, 32'd1);
    load("status_after_reset", 32'h0000_0408, 3'b000, exp_status(2'b10));

`ifdef UART_LOOPBACK_EN
    store(32'h0000_040C, 32'h0000_0001, 2'b11);
    load("ctrl_readback", 32'h0000_040C, 3'b000, 32'd1);
    store(32'h0000_0400, 32'h0000_005A, 2'b11);
    saw_low = 1'b0;
    for (int i = 0; i < 14 * CPB; i++) begin
      if (tx !== 1'b1) saw_low = 1'b1;
      idle(1);
    end
    check("loopback_tx_held", {31'd0, saw_low}, 32'd0);
    rx_m.push_back(8'h5A);
    read_rx("loopback_rx", 3'b000);
    store(32'h0000_040C, 32'h0000_0000, 2'b11);
`else
    saw_low = 1'b0;
    bus.ADDR = 32'h0000_040C;
    #1;
    check("sel_no_ctrl", {31'd0, bus.SEL}, 32'd0);
    check("rd_no_ctrl", bus.RD, 32'd0);
`endif

    idle(4);
    check("scoreboard_drained", 32'(rd_exp.size() + tx_exp.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
